// File: rtl/mobilenet_v1_pw_weight_fetch.sv
// Pointwise weight tile fetcher: a miss issues one read burst and packs BEATS beats into pw_weight, and a repeated tile is served from a one-entry tag.
// Latency is 2 cycles on a hit, or 1 + AR wait + BEATS + 1 on a miss; every handshake is valid/ready and the response holds until resp_ready.
module mobilenet_v1_pw_weight_fetch #(
  parameter int DATA_W    = 8,
  parameter int PW_OC_PAR = 16,
  parameter int PW_IC_PAR = 8,
  parameter int MEM_W     = 64,
  parameter int ADDR_W    = 32,
  parameter int DIM_W     = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [ADDR_W-1:0]                             req_base_addr,
  input  logic [DIM_W-1:0]                              req_oc_group,
  input  logic [DIM_W-1:0]                              req_ic_group,
  input  logic [DIM_W-1:0]                              req_num_ic_groups,
  input  logic                                          invalidate,
  output logic                                          mem_ar_valid,
  input  logic                                          mem_ar_ready,
  output logic [ADDR_W-1:0]                             mem_ar_addr,
  output logic [DIM_W-1:0]                              mem_ar_len,
  input  logic                                          mem_r_valid,
  output logic                                          mem_r_ready,
  input  logic [MEM_W-1:0]                              mem_r_data,
  output logic                                          resp_valid,
  input  logic                                          resp_ready,
  output logic                                          resp_hit,
  output logic signed [PW_OC_PAR*PW_IC_PAR*DATA_W-1:0]  pw_weight,
  output logic                                          busy
);

  localparam int TILE_W     = PW_OC_PAR * PW_IC_PAR * DATA_W;
  localparam int BEATS      = TILE_W / MEM_W;
  localparam int TILE_BYTES = TILE_W / 8;
  localparam int BC_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (TILE_W % MEM_W != 0) begin : g_bad_cfg
      $error("TILE_W must be a multiple of MEM_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_FILL, S_RESP} state_t;

  state_t              r_state;
  logic                r_tag_valid;
  logic [ADDR_W-1:0]   r_tag_base;
  logic [ADDR_W-1:0]   r_tag_idx;
  logic [ADDR_W-1:0]   r_cur_base;
  logic [ADDR_W-1:0]   r_cur_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [BC_W-1:0]     r_beat_cnt;
  logic                r_kill_pending;
  logic                r_hit;
  logic [TILE_W-1:0]   r_pw_weight;

  logic [ADDR_W-1:0]   w_tile_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_hit;
  logic                w_last_beat;

  assign w_tile_idx  = ADDR_W'(req_oc_group) * ADDR_W'(req_num_ic_groups) + ADDR_W'(req_ic_group);
  assign w_addr      = req_base_addr + w_tile_idx * ADDR_W'(TILE_BYTES);
  assign w_hit       = r_tag_valid && (r_tag_base == req_base_addr) && (r_tag_idx == w_tile_idx) && !invalidate;
  assign w_last_beat = (r_beat_cnt == BC_W'(BEATS - 1));

  assign req_ready    = (r_state == S_IDLE);
  assign mem_ar_valid = (r_state == S_ADDR);
  assign mem_ar_addr  = r_addr;
  assign mem_ar_len   = DIM_W'(BEATS);
  assign mem_r_ready  = (r_state == S_FILL);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_hit     = r_hit;
  assign pw_weight    = r_pw_weight;
  assign busy         = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_tag_valid    <= 1'b0;
      r_tag_base     <= '0;
      r_tag_idx      <= '0;
      r_cur_base     <= '0;
      r_cur_idx      <= '0;
      r_addr         <= '0;
      r_beat_cnt     <= '0;
      r_kill_pending <= 1'b0;
      r_hit          <= 1'b0;
      r_pw_weight    <= '0;
    end else begin
      if (invalidate) r_tag_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cur_base <= req_base_addr;
            r_cur_idx  <= w_tile_idx;
            r_addr     <= w_addr;
            r_hit      <= w_hit;
            r_state    <= w_hit ? S_RESP : S_ADDR;
          end
        end
        S_ADDR: begin
          if (invalidate) r_kill_pending <= 1'b1;
          if (mem_ar_ready) begin
            r_beat_cnt <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (invalidate) r_kill_pending <= 1'b1;
          if (mem_r_valid) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_beat_cnt == BC_W'(b)) r_pw_weight[b*MEM_W +: MEM_W] <= mem_r_data;
            end
            r_beat_cnt <= r_beat_cnt + BC_W'(1);
            // An invalidate seen at any point of this fill keeps the new tag invalid.
            if (w_last_beat) begin
              r_tag_base     <= r_cur_base;
              r_tag_idx      <= r_cur_idx;
              r_tag_valid    <= !r_kill_pending && !invalidate;
              r_kill_pending <= 1'b0;
              r_hit          <= 1'b0;
              r_state        <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mobilenet_v1_pw_weight_fetch.sv
// Directed bench for the pointwise weight fetcher: the stimulus queues the expected AR and response beats,
// and a negedge monitor pops and compares them whenever the DUT completes a handshake.
module tb_mobilenet_v1_pw_weight_fetch;

  localparam int TILE_W = 1024;
  localparam int MEM_W  = 64;
  localparam int BEATS  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid, req_ready;
  logic [31:0]         req_base_addr;
  logic [15:0]         req_oc_group, req_ic_group, req_num_ic_groups;
  logic                invalidate;
  logic                mem_ar_valid, mem_ar_ready;
  logic [31:0]         mem_ar_addr;
  logic [15:0]         mem_ar_len;
  logic                mem_r_valid, mem_r_ready;
  logic [63:0]         mem_r_data;
  logic                resp_valid, resp_ready, resp_hit;
  logic signed [TILE_W-1:0] pw_weight;
  logic                busy;

  typedef struct {
    logic              hit;
    logic [TILE_W-1:0] w;
  } resp_t;

  logic [31:0] exp_ar[$];
  resp_t       exp_resp[$];
  int          checks = 0;
  int          failures = 0;
  int          ar_seen = 0;

  mobilenet_v1_pw_weight_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_addr(req_base_addr), .req_oc_group(req_oc_group),
    .req_ic_group(req_ic_group), .req_num_ic_groups(req_num_ic_groups),
    .invalidate(invalidate),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
    .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len),
    .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .pw_weight(pw_weight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_tile(input string nm, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
    int bad;
    bad = -1;
    for (int k = BEATS - 1; k >= 0; k--)
      if (act[k*MEM_W +: MEM_W] !== exp[k*MEM_W +: MEM_W]) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s beat=%0d got=%h want=%h", nm, bad, act[bad*MEM_W +: MEM_W], exp[bad*MEM_W +: MEM_W]);
    end
  endtask

  function automatic logic [63:0] beat(input logic [63:0] seed, input int k);
    logic [63:0] kk;
    kk = 64'(k);
    return (64'h0101010101010101 * kk) ^ seed;
  endfunction

  function automatic logic [TILE_W-1:0] tile(input logic [63:0] seed);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int k = 0; k < BEATS; k++) t[k*MEM_W +: MEM_W] = beat(seed, k);
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_ar_valid && exp_ar.size() == 0) chk("unexpected_ar", {63'd0, mem_ar_valid}, 64'd0);
      if (mem_ar_valid && mem_ar_ready) begin
        ar_seen++;
        if (exp_ar.size() > 0) begin
          logic [31:0] ea;
          ea = exp_ar.pop_front();
          chk("ar_addr", {32'd0, mem_ar_addr}, {32'd0, ea});
          chk("ar_len", {48'd0, mem_ar_len}, 64'd16);
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
        else begin
          resp_t er;
          er = exp_resp.pop_front();
          chk("resp_hit", {63'd0, resp_hit}, {63'd0, er.hit});
          chk_tile("resp_weight", pw_weight, er.w);
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] base, input logic [15:0] oc, input logic [15:0] ic,
                        input logic [15:0] num, input bit hit);
    int t;
    t = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_base_addr = base; req_oc_group = oc;
    req_ic_group = ic; req_num_ic_groups = num;
    @(negedge clk);
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) chk("req_accept_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (hit) begin
      @(negedge clk);
      chk("hit_resp_latency", {63'd0, resp_valid}, 64'd1);
      chk("hit_no_ar", {63'd0, mem_ar_valid}, 64'd0);
    end
  endtask

  // Plays the memory side: optional AR stall with junk on R, beats with gaps, optional invalidate pulse.
  task automatic serve(input logic [31:0] eaddr, input logic [63:0] seed, input int ar_stall,
                       input int gap_mask, input int nbeats, input int inv_beat);
    int t;
    t = 0;
    @(negedge clk);
    while (!mem_ar_valid && t < 50) begin @(negedge clk); t++; end
    if (!mem_ar_valid) chk("ar_timeout", {63'd0, mem_ar_valid}, 64'd1);
    for (int i = 0; i < ar_stall; i++) begin
      mem_r_valid = 1'b1; mem_r_data = 64'hDEAD_BEEF_0BAD_F00D;
      chk("ar_addr_stable", {32'd0, mem_ar_addr}, {32'd0, eaddr});
      chk("ar_len_stable", {48'd0, mem_ar_len}, 64'd16);
      chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
      chk("r_ready_in_addr", {63'd0, mem_r_ready}, 64'd0);
      @(negedge clk);
    end
    mem_r_valid = 1'b0;
    @(posedge clk); #1; mem_ar_ready = 1'b1;
    @(posedge clk); #1; mem_ar_ready = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (gap_mask[k]) begin
        mem_r_valid = 1'b0; mem_r_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
      end
      mem_r_valid = 1'b1; mem_r_data = beat(seed, k);
      invalidate = (k == inv_beat);
      t = 0;
      @(negedge clk);
      while (!mem_r_ready && t < 50) begin @(negedge clk); t++; end
      if (!mem_r_ready) chk("r_ready_timeout", {63'd0, mem_r_ready}, 64'd1);
      @(posedge clk); #1;
      mem_r_valid = 1'b0; invalidate = 1'b0;
    end
    if (nbeats == BEATS) begin
      @(negedge clk);
      chk("resp_after_last_beat", {63'd0, resp_valid}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    rst_n = 1'b0; req_valid = 1'b0; req_base_addr = '0; req_oc_group = '0;
    req_ic_group = '0; req_num_ic_groups = '0; invalidate = 1'b0;
    mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0; resp_ready = 1'b1;
    #3;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ar_valid", {63'd0, mem_ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, mem_r_ready}, 64'd0);
    chk("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    chk_tile("rst_weight", pw_weight, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: miss, idx=1*4+2=6, addr=0x1000+6*128=0x1300
    exp_ar.push_back(32'h1300);
    r.hit = 1'b0; r.w = tile(64'h0); exp_resp.push_back(r);
    do_req(32'h1000, 16'd1, 16'd2, 16'd4, 1'b0);
    serve(32'h1300, 64'h0, 0, 0, BEATS, -1);
    repeat (3) @(negedge clk);
    chk("t1_ar_once", 64'(ar_seen), 64'd1);

    // 2: same tile hits, weights unchanged
    r.hit = 1'b1; r.w = tile(64'h0); exp_resp.push_back(r);
    do_req(32'h1000, 16'd1, 16'd2, 16'd4, 1'b1);
    repeat (2) @(negedge clk);

    // 3: backpressure on every channel, tile (0,1) -> 0x1080
    resp_ready = 1'b0;
    exp_ar.push_back(32'h1080);
    r.hit = 1'b0; r.w = tile(64'hA5A5_0000_5A5A_FFFF); exp_resp.push_back(r);
    do_req(32'h1000, 16'd0, 16'd1, 16'd4, 1'b0);
    serve(32'h1080, 64'hA5A5_0000_5A5A_FFFF, 5, (1 << 3) | (1 << 7) | (1 << 12), BEATS, -1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_resp_held", {63'd0, resp_valid}, 64'd1);
      chk_tile("t3_weight_held", pw_weight, tile(64'hA5A5_0000_5A5A_FFFF));
      chk("t3_req_ready_low", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // 4: invalidate mid-fill of (0,0); response still delivered, re-request misses
    exp_ar.push_back(32'h1000);
    r.hit = 1'b0; r.w = tile(64'h1111_1111_1111_1111); exp_resp.push_back(r);
    do_req(32'h1000, 16'd0, 16'd0, 16'd4, 1'b0);
    serve(32'h1000, 64'h1111_1111_1111_1111, 0, 0, BEATS, 8);
    exp_ar.push_back(32'h1000);
    r.hit = 1'b0; r.w = tile(64'h2222_2222_2222_2222); exp_resp.push_back(r);
    do_req(32'h1000, 16'd0, 16'd0, 16'd4, 1'b0);
    serve(32'h1000, 64'h2222_2222_2222_2222, 0, 0, BEATS, -1);

    // 5: other base, same tile index -> miss at 0x2000
    exp_ar.push_back(32'h2000);
    r.hit = 1'b0; r.w = tile(64'h3333_0000_3333_0000); exp_resp.push_back(r);
    do_req(32'h2000, 16'd0, 16'd0, 16'd4, 1'b0);
    serve(32'h2000, 64'h3333_0000_3333_0000, 0, 0, BEATS, -1);

    // 6: reset after beat 7 of tile (1,0) at 0x2200, then the previously tagged tile misses
    exp_ar.push_back(32'h2200);
    do_req(32'h2000, 16'd1, 16'd0, 16'd4, 1'b0);
    serve(32'h2200, 64'h4444_4444_0000_0000, 0, 0, 8, -1);
    rst_n = 1'b0; mem_r_valid = 1'b1; mem_r_data = 64'hCAFE_CAFE_CAFE_CAFE;
    #1;
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk_tile("t6_weight", pw_weight, '0);
    chk("t6_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_r_ready_idle", {63'd0, mem_r_ready}, 64'd0);
    mem_r_valid = 1'b0;
    exp_ar.push_back(32'h2000);
    r.hit = 1'b0; r.w = tile(64'h5555_AAAA_5555_AAAA); exp_resp.push_back(r);
    do_req(32'h2000, 16'd0, 16'd0, 16'd4, 1'b0);
    serve(32'h2000, 64'h5555_AAAA_5555_AAAA, 0, 0, BEATS, -1);

    repeat (4) @(negedge clk);
    chk("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
    chk("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    chk("ar_total", 64'(ar_seen), 64'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
